wb_sched: RTL and testbench

Writeback scheduler for the single register-file write port. It arbitrates between instructions leaving the execute stage (ALU, PC+4 and immediate results) and load data returning late from data memory. It buffers up to two load returns and drives the writeback mux select, destination register, write enable and load data, all registered, one cycle after each grant.

---
 rtl/wb_sched.sv | 109 ++++++++++
 tb/tb_wb_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_sched.sv
// Writeback scheduler: arbitrates the single register-file write port between
// execute-stage results and late load returns held in a 2-entry buffer.
module wb_sched #(
   parameter int unsigned REGW   = 5,
   parameter int unsigned DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [1:0]        ex_wbsel,
   input  logic [REGW-1:0]   ex_rd,
   output logic              ex_ready,
   input  logic              ld_valid,
   input  logic [REGW-1:0]   ld_rd,
   input  logic [DWIDTH-1:0] ld_data,
   output logic              ld_ready,
   output logic [1:0]        ld_count,
   output logic [1:0]        wb_sel,
   output logic [REGW-1:0]   wb_rd,
   output logic              wb_we,
   output logic [DWIDTH-1:0] wb_ldata
);

   localparam logic [1:0] SelLoad = 2'b00;
   localparam logic [1:0] SelAlu  = 2'b01;
   localparam logic [1:0] Full    = 2'd2;

   logic [1:0]        count_q;
   logic [1:0]        streak_q;
   logic [REGW-1:0]   rd0_q, rd1_q;
   logic [DWIDTH-1:0] data0_q, data1_q;
   logic              have_l, e_grant, l_grant, push, pop;

   assign ld_count = count_q;

   // Handshakes and grant decode; readies depend only on registered state.
   always_comb begin
      have_l   = (count_q != 2'd0);
      ld_ready = !rst && (count_q != Full);
      ex_ready = !rst && (!have_l || (streak_q == Full));
      e_grant  = ex_valid && ex_ready;
      l_grant  = !rst && have_l && !e_grant;
      push     = ld_valid && ld_ready;
      pop      = l_grant;
   end

   // Buffer occupancy; a pop never frees a slot for a same-cycle push.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
      end else if (push && !pop) begin
         count_q <= count_q + 2'd1;
      end else if (pop && !push) begin
         count_q <= count_q - 2'd1;
      end
   end

   // Buffer storage: entry 0 is always the head, entry 1 shifts down on pop.
   always_ff @(posedge clk) begin
      if (pop) begin
         if (push && (count_q == 2'd1)) begin
            rd0_q   <= ld_rd;
            data0_q <= ld_data;
         end else begin
            rd0_q   <= rd1_q;
            data0_q <= data1_q;
         end
      end else if (push) begin
         if (count_q == 2'd0) begin
            rd0_q   <= ld_rd;
            data0_q <= ld_data;
         end else begin
            rd1_q   <= ld_rd;
            data1_q <= ld_data;
         end
      end
   end

   // Consecutive load grants taken while execute is waiting; saturates at 2.
   always_ff @(posedge clk) begin
      if (rst || !ex_valid || e_grant) begin
         streak_q <= 2'd0;
      end else if (l_grant && (streak_q != Full)) begin
         streak_q <= streak_q + 2'd1;
      end
   end

   // Registered writeback outputs, one cycle after the grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we    <= 1'b0;
         wb_sel   <= SelAlu;
         wb_rd    <= '0;
         wb_ldata <= '0;
      end else if (l_grant) begin
         wb_we    <= (rd0_q != '0);
         wb_sel   <= SelLoad;
         wb_rd    <= rd0_q;
         wb_ldata <= data0_q;
      end else if (e_grant) begin
         wb_we    <= (ex_rd != '0);
         wb_sel   <= ex_wbsel;
         wb_rd    <= ex_rd;
      end else begin
         wb_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_sched.sv
// Bench for wb_sched: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_wb_sched;

   logic        clk, rst;
   logic        ex_valid, ex_ready, ld_valid, ld_ready, wb_we;
   logic [1:0]  ex_wbsel, ld_count, wb_sel;
   logic [4:0]  ex_rd, ld_rd, wb_rd;
   logic [31:0] ld_data, wb_ldata;

   int n_cmp = 0;
   int n_fail = 0;
   logic seen9 = 1'b0;

   wb_sched #(.REGW(5), .DWIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_wbsel(ex_wbsel), .ex_rd(ex_rd), .ex_ready(ex_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_count(ld_count), .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_we(wb_we),
      .wb_ldata(wb_ldata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: loads as a queue, arbitration from the grant rules.
   logic [4:0]  qrd[$];
   logic [31:0] qd[$];
   int          mstreak;
   logic        m_we;
   logic [1:0]  m_sel;
   logic [4:0]  m_rd;
   logic [31:0] m_ld;

   initial begin
      logic exr, ldr, have_l, ge, gl;
      @(posedge clk);
      m_we = 1'b0; m_sel = 2'b01; m_rd = '0; m_ld = '0; mstreak = 0;
      forever begin
         @(negedge clk);
         exr = !rst && (qrd.size() == 0 || mstreak == 2);
         ldr = !rst && (qrd.size() < 2);
         chk("ex_ready", 32'(ex_ready), 32'(exr));
         chk("ld_ready", 32'(ld_ready), 32'(ldr));
         chk("ld_count", 32'(ld_count), 32'(qrd.size()));
         chk("wb_we", 32'(wb_we), 32'(m_we));
         chk("wb_sel", 32'(wb_sel), 32'(m_sel));
         chk("wb_rd", 32'(wb_rd), 32'(m_rd));
         chk("wb_ldata", wb_ldata, m_ld);
         if (wb_we && wb_rd == 5'd9) seen9 = 1'b1;
         if (rst) begin
            qrd.delete(); qd.delete();
            m_we = 1'b0; m_sel = 2'b01; m_rd = '0; m_ld = '0; mstreak = 0;
         end else begin
            have_l = (qrd.size() > 0);
            // Execute wins when alone, or when loads have had two turns in a row.
            ge = ex_valid && (!have_l || mstreak == 2);
            gl = have_l && !ge;
            if (gl) begin
               m_sel = 2'b00; m_rd = qrd[0]; m_ld = qd[0]; m_we = (qrd[0] != '0);
               void'(qrd.pop_front()); void'(qd.pop_front());
            end else if (ge) begin
               m_sel = ex_wbsel; m_rd = ex_rd; m_we = (ex_rd != '0);
            end else begin
               m_we = 1'b0;
            end
            if (!ex_valid || ge) mstreak = 0;
            else if (gl && mstreak < 2) mstreak++;
            if (ld_valid && ldr) begin
               qrd.push_back(ld_rd); qd.push_back(ld_data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int ldi;
      rst = 1'b1; ex_valid = 1'b1; ex_wbsel = 2'b01; ex_rd = 5'd3;
      ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h1;
      // Reset held two cycles with both requesters active.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_ex_ready", 32'(ex_ready), 32'd0);
         chk("rst_ld_ready", 32'(ld_ready), 32'd0);
         chk("rst_wb_we", 32'(wb_we), 32'd0);
         chk("rst_wb_sel", 32'(wb_sel), 32'd1);
         chk("rst_ld_count", 32'(ld_count), 32'd0);
      end
      step(); rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_ld_ready", 32'(ld_ready), 32'd1);
      chk("post_rst_ex_ready", 32'(ex_ready), 32'd1);

      // ALU only
      step(); ex_valid = 1'b1; ex_wbsel = 2'b01; ex_rd = 5'd5;
      @(negedge clk);
      chk("alu_ex_ready", 32'(ex_ready), 32'd1);
      step(); ex_valid = 1'b0;
      @(negedge clk);
      chk("alu_we", 32'(wb_we), 32'd1);
      chk("alu_sel", 32'(wb_sel), 32'd1);
      chk("alu_rd", 32'(wb_rd), 32'd5);

      // Load only
      step(); ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEADBEEF;
      step(); ld_valid = 1'b0;
      @(negedge clk);
      chk("ld_count_1", 32'(ld_count), 32'd1);
      chk("ld_we_early", 32'(wb_we), 32'd0);
      step();
      @(negedge clk);
      chk("ld_we", 32'(wb_we), 32'd1);
      chk("ld_sel", 32'(wb_sel), 32'd0);
      chk("ld_rd", 32'(wb_rd), 32'd7);
      chk("ld_data", wb_ldata, 32'hDEADBEEF);

      // x0 suppression, execute then load
      step(); ex_valid = 1'b1; ex_wbsel = 2'b10; ex_rd = 5'd0;
      step(); ex_valid = 1'b0;
      @(negedge clk);
      chk("x0_ex_we", 32'(wb_we), 32'd0);
      chk("x0_ex_sel", 32'(wb_sel), 32'd2);
      step(); ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
      step(); ld_valid = 1'b0;
      step();
      @(negedge clk);
      chk("x0_ld_we", 32'(wb_we), 32'd0);
      chk("x0_ld_sel", 32'(wb_sel), 32'd0);
      chk("x0_ld_data", wb_ldata, 32'h55);

      // Contention: grants go E, L, L, E, L, L, E ...; rd 9 offered while full.
      ldi = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         ex_valid = 1'b1; ex_wbsel = 2'b01; ex_rd = 5'(20 + k);
         ld_valid = 1'b1;
         if (k == 4) begin
            ld_rd = 5'd9; ld_data = 32'h99;
         end else begin
            ld_rd = 5'(10 + ldi); ld_data = 32'hA0 + 32'(ldi);
         end
         @(negedge clk);
         if (k == 3) chk("fair_ex_ready", 32'(ex_ready), 32'd1);
         if (k == 4) begin
            chk("full_count", 32'(ld_count), 32'd2);
            chk("full_ld_ready", 32'(ld_ready), 32'd0);
            chk("full_ex_ready", 32'(ex_ready), 32'd0);
            chk("fair_e_sel", 32'(wb_sel), 32'd1);
            chk("fair_e_rd", 32'(wb_rd), 32'd23);
         end
         if (k == 5) begin
            chk("resume_l_sel", 32'(wb_sel), 32'd0);
            chk("resume_l_rd", 32'(wb_rd), 32'd12);
            chk("after_pop_count", 32'(ld_count), 32'd1);
         end
         if (ld_ready) ldi++;
      end
      step(); ex_valid = 1'b0; ld_valid = 1'b0;
      repeat (5) step();
      @(negedge clk);
      chk("rd9_never_written", 32'(seen9), 32'd0);
      chk("drained_count", 32'(ld_count), 32'd0);

      // Reset mid-operation
      step(); ex_valid = 1'b1; ex_wbsel = 2'b11; ex_rd = 5'd6;
      ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
      repeat (3) step();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ex_ready", 32'(ex_ready), 32'd0);
      chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
      step(); rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0;
      @(negedge clk);
      chk("midrst_we", 32'(wb_we), 32'd0);
      chk("midrst_count", 32'(ld_count), 32'd0);
      repeat (2) step();
      @(negedge clk);
      chk("midrst_no_write", 32'(wb_we), 32'd0);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
